pbit_sweep_scheduler: RTL and testbench

- Top-level sequencer for the time-multiplexed p-bit array.
- Walks rows 0..NUM_PBITS-1 through the weight/bias loader, one row per update, and triggers the p-bit update engine after each row's stream completes.
- Releases the loader with a compute_done pulse before moving to the next row.
- Repeats full sweeps until the programmed sweep count is reached or an abort is requested; includes a loader watchdog.

---
 rtl/pbit_sweep_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pbit_sweep_scheduler
// Purpose  : Top-level sequencer for a time-multiplexed p-bit array. It walks
//            rows 0..NUM_PBITS-1 through the weight/bias loader. After each
//            row's stream has loaded, it triggers the p-bit update engine.
//            Once the update is acknowledged, it releases the loader with a
//            compute_done pulse. Full sweeps repeat until the programmed
//            sweep count is reached or an abort is honoured. A watchdog
//            guards the loader and engine handshakes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   run          in   1        pulse: start a run of num_sweeps sweeps
//   abort        in   1        pulse: stop after the row in flight completes
//   num_sweeps   in   SWEEP_W  sweeps to execute, sampled with run
//   start_load   out  1        one-cycle pulse to the loader
//   current_row  out  ROW_W    row being loaded/updated
//   load_done    in   1        loader level: a finished row is held
//   compute_done out  1        one-cycle pulse releasing the loader
//   upd_start    out  1        one-cycle pulse: update p-bit current_row
//   upd_ack      in   1        pulse from the update engine: update committed
//   busy         out  1        high from run acceptance until back in IDLE
//   sweep_done   out  1        one-cycle pulse at the end of every sweep
//   run_done     out  1        one-cycle pulse at the end of a run
//   sweep_count  out  SWEEP_W  completed sweeps in the current run
//   error        out  1        sticky watchdog flag
// ============================================================================
module pbit_sweep_scheduler #(
  parameter int NUM_PBITS = 16,
  parameter int ROW_W     = $clog2(NUM_PBITS + 1),
  parameter int SWEEP_W   = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               abort,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic               start_load,
  output logic [ROW_W-1:0]   current_row,
  input  logic               load_done,
  output logic               compute_done,
  output logic               upd_start,
  input  logic               upd_ack,
  output logic               busy,
  output logic               sweep_done,
  output logic               run_done,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic               error
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(NUM_PBITS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = TIMER_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_LOAD = 3'd2,
    S_UPDATE    = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_RELEASE   = 3'd5,
    S_NEXT      = 3'd6
  } state_t;

  state_t               state;
  logic [ROW_W-1:0]     row;
  logic [TIMER_W-1:0]   timer;
  logic [SWEEP_W-1:0]   num_latched;
  logic                 abort_pend;
  // Set when a watchdog expiry sends the row through RELEASE. NEXT then ends
  // the run without advancing the row or the sweep count.
  logic                 timed_out;

  logic                 last_row;
  logic [SWEEP_W-1:0]   sweep_inc;
  logic                 run_complete;
  logic                 abort_now;
  logic                 timer_expired;

  // The row register is the output directly. It only moves in NEXT, after
  // compute_done, so it stays stable across the start_load..compute_done span.
  assign current_row   = row;

  assign last_row      = (row == LAST_ROW);
  assign sweep_inc     = sweep_count + SWEEP_W'(1);
  assign run_complete  = last_row && (sweep_inc == num_latched);
  // An abort that arrives in the same cycle as NEXT is honoured immediately.
  assign abort_now     = abort_pend | abort;
  assign timer_expired = (timer == TIMER_LIMIT);

  // All outputs are registered. Each pulse is raised on the transition into
  // the state that owns it, so the pulse is high while that state is current.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      row          <= '0;
      timer        <= '0;
      num_latched  <= '0;
      abort_pend   <= 1'b0;
      timed_out    <= 1'b0;
      start_load   <= 1'b0;
      compute_done <= 1'b0;
      upd_start    <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
      run_done     <= 1'b0;
      sweep_count  <= '0;
      error        <= 1'b0;
    end else begin
      start_load   <= 1'b0;
      compute_done <= 1'b0;
      upd_start    <= 1'b0;
      sweep_done   <= 1'b0;
      run_done     <= 1'b0;

      if (busy && abort) begin
        abort_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (run) begin
            if (num_sweeps != '0) begin
              num_latched <= num_sweeps;
              row         <= '0;
              sweep_count <= '0;
              error       <= 1'b0;
              abort_pend  <= 1'b0;
              timed_out   <= 1'b0;
              timer       <= '0;
              busy        <= 1'b1;
              start_load  <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              // A zero-length run completes at once and never raises busy.
              run_done <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_LOAD;
        end

        S_WAIT_LOAD: begin
          if (load_done) begin
            upd_start <= 1'b1;
            state     <= S_UPDATE;
          end else if (timer_expired) begin
            // Free the loader, then finish the run from NEXT.
            error        <= 1'b1;
            timed_out    <= 1'b1;
            compute_done <= 1'b1;
            state        <= S_RELEASE;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + TIMER_W'(1);
          end
        end

        S_UPDATE: begin
          // upd_ack is not looked at here. An ack that coincides with
          // upd_start therefore never completes the handshake.
          timer <= '0;
          state <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (upd_ack) begin
            compute_done <= 1'b1;
            state        <= S_RELEASE;
          end else if (timer_expired) begin
            error        <= 1'b1;
            timed_out    <= 1'b1;
            compute_done <= 1'b1;
            state        <= S_RELEASE;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + TIMER_W'(1);
          end
        end

        S_RELEASE: begin
          state <= S_NEXT;
        end

        S_NEXT: begin
          if (timed_out) begin
            run_done <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            if (last_row) begin
              row         <= '0;
              sweep_count <= sweep_inc;
              sweep_done  <= 1'b1;
            end else begin
              row <= row + ROW_W'(1);
            end

            // An abort that lands together with the final sweep still
            // yields a single run_done.
            if (abort_now || run_complete) begin
              run_done <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              start_load <= 1'b1;
              state      <= S_ISSUE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbit_sweep_scheduler
// Purpose  : Self-checking bench for pbit_sweep_scheduler. It contains a
//            loader model (load_done 3 cycles after start_load, held until
//            compute_done) and an engine model (upd_ack 2 cycles after
//            upd_start). The expected row order and end-of-run results are
//            queued when stimulus is issued, then popped as the DUT produces
//            its pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbit_sweep_scheduler;

  localparam int NP       = 4;
  localparam int SW       = 16;
  localparam int TO       = 16;
  localparam int RW       = $clog2(NP + 1);
  localparam int LOAD_LAT = 3;
  localparam int ACK_LAT  = 2;

  logic          clk;
  logic          reset;
  logic          run;
  logic          abort;
  logic [SW-1:0] num_sweeps;
  logic          start_load;
  logic [RW-1:0] current_row;
  logic          load_done;
  logic          compute_done;
  logic          upd_start;
  logic          upd_ack;
  logic          busy;
  logic          sweep_done;
  logic          run_done;
  logic [SW-1:0] sweep_count;
  logic          error;

  pbit_sweep_scheduler #(
    .NUM_PBITS(NP),
    .ROW_W    (RW),
    .SWEEP_W  (SW),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .abort       (abort),
    .num_sweeps  (num_sweeps),
    .start_load  (start_load),
    .current_row (current_row),
    .load_done   (load_done),
    .compute_done(compute_done),
    .upd_start   (upd_start),
    .upd_ack     (upd_ack),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .run_done    (run_done),
    .sweep_count (sweep_count),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard queues
  typedef struct {
    int cnt;
    int err;
  } run_exp_t;

  int       exp_rows[$];
  run_exp_t exp_runs[$];

  // Event counters and time stamps collected by the monitor
  int n_start = 0, n_upd = 0, n_cd = 0, n_sd = 0, n_rd = 0;
  int start_cyc[$];
  int sd_cd[$];
  int rd_cyc[$];
  int held_row = 0;

  // Snapshots taken before each scenario
  int s_start, s_upd, s_cd, s_sd, s_rd;

  bit loader_en = 1'b1;
  int ld_cnt    = 0;
  int ack_cnt   = 0;

  // Loader model
  always @(negedge clk) begin
    if (reset) begin
      load_done = 1'b0;
      ld_cnt    = 0;
    end else begin
      if (start_load && loader_en) begin
        ld_cnt = LOAD_LAT;
      end else if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) load_done = 1'b1;
      end
      if (compute_done) load_done = 1'b0;
    end
  end

  // Update-engine model
  always @(negedge clk) begin
    upd_ack = 1'b0;
    if (reset) begin
      ack_cnt = 0;
    end else if (upd_start) begin
      ack_cnt = ACK_LAT;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) upd_ack = 1'b1;
    end
  end

  // Monitor: compares DUT pulses against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (start_load) begin
        n_start++;
        start_cyc.push_back(cyc);
        held_row = int'(current_row);
        if (exp_rows.size() == 0) check("row_extra", longint'(current_row), 99);
        else check("row_order", longint'(current_row), longint'(exp_rows.pop_front()));
      end
      if (upd_start) begin
        n_upd++;
        check("upd_row_stable", longint'(current_row), longint'(held_row));
      end
      if (compute_done) begin
        n_cd++;
        check("cd_row_stable", longint'(current_row), longint'(held_row));
      end
      if (sweep_done) begin
        n_sd++;
        sd_cd.push_back(n_cd);
      end
      if (run_done) begin
        run_exp_t e;
        n_rd++;
        rd_cyc.push_back(cyc);
        if (exp_runs.size() == 0) begin
          check("run_done_extra", longint'(run_done), 0);
        end else begin
          e = exp_runs.pop_front();
          check("run_sweep_count", longint'(sweep_count), longint'(e.cnt));
          check("run_error", longint'(error), longint'(e.err));
          check("busy_at_run_done", longint'(busy), 0);
        end
      end
    end
  end

  task automatic snap();
    s_start = n_start;
    s_upd   = n_upd;
    s_cd    = n_cd;
    s_sd    = n_sd;
    s_rd    = n_rd;
  endtask

  task automatic push_sweep_rows(input int sweeps);
    for (int s = 0; s < sweeps; s++)
      for (int r = 0; r < NP; r++) exp_rows.push_back(r);
  endtask

  task automatic push_run(input int cnt, input int err);
    run_exp_t e;
    e.cnt = cnt;
    e.err = err;
    exp_runs.push_back(e);
  endtask

  // Called at a negedge; drives run for exactly one cycle.
  task automatic pulse_run(input int n);
    num_sweeps = SW'(n);
    run        = 1'b1;
    @(negedge clk);
    run        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_rd == s_rd && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_run_done_seen"}, longint'(n_rd - s_rd), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Hard stop in case the stimulus itself wedges
  initial begin
    #300000;
    $display("FAIL global_timeout: observed cycle %0d, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int  k;
    bit  seen;
    int  rcyc;
    int  lat;

    reset      = 1'b1;
    run        = 1'b0;
    abort      = 1'b0;
    num_sweeps = '0;
    load_done  = 1'b0;
    upd_ack    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          longint'({start_load, compute_done, upd_start, busy, sweep_done,
                    run_done, error, sweep_count, current_row}), 0);
    reset = 1'b0;

    // ---- single sweep, run issued at cycle 10 ----
    while (cyc < 10) @(negedge clk);
    snap();
    push_sweep_rows(1);
    push_run(1, 0);
    pulse_run(1);
    wait_done("one_sweep", 300);
    check("start_at_cycle_11", (start_cyc.size() > s_start) ? longint'(start_cyc[s_start]) : -1, 11);
    check("one_sweep_starts", longint'(n_start - s_start), NP);

    // ---- zero-length run ----
    repeat (2) @(negedge clk);
    snap();
    push_run(1, 0);
    rcyc = cyc;
    pulse_run(0);
    wait_done("zero", 20);
    check("zero_done_latency", (rd_cyc.size() > s_rd) ? longint'(rd_cyc[s_rd] - rcyc) : -1, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= busy;
      @(negedge clk);
    end
    check("zero_busy_never", longint'(seen), 0);
    check("zero_no_start", longint'(n_start - s_start), 0);

    // ---- two full sweeps ----
    snap();
    push_sweep_rows(2);
    push_run(2, 0);
    pulse_run(2);
    wait_done("two_sweeps", 500);
    repeat (6) @(negedge clk);
    check("two_starts", longint'(n_start - s_start), 2 * NP);
    check("two_upds", longint'(n_upd - s_upd), 2 * NP);
    check("two_cds", longint'(n_cd - s_cd), 2 * NP);
    check("two_sweep_dones", longint'(n_sd - s_sd), 2);
    check("two_single_run_done", longint'(n_rd - s_rd), 1);
    check("sweep_done_1_after_row3", (sd_cd.size() > s_sd) ? longint'(sd_cd[s_sd] - s_cd) : -1, NP);
    check("sweep_done_2_after_row7", (sd_cd.size() > s_sd + 1) ? longint'(sd_cd[s_sd + 1] - s_cd) : -1, 2 * NP);
    check("two_count_held", longint'(sweep_count), 2);
    check("two_busy_low", longint'(busy), 0);

    // ---- abort during WAIT_ACK of row 1, sweep 0 ----
    snap();
    exp_rows.push_back(0);
    exp_rows.push_back(1);
    push_run(0, 0);
    pulse_run(2);
    k = 0;
    while (!(upd_start && current_row == RW'(1)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("abort_row1_update_seen", longint'(upd_start && current_row == RW'(1)), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 200);
    repeat (6) @(negedge clk);
    check("abort_starts", longint'(n_start - s_start), 2);
    check("abort_upds", longint'(n_upd - s_upd), 2);
    check("abort_cds", longint'(n_cd - s_cd), 2);
    check("abort_no_sweep_done", longint'(n_sd - s_sd), 0);
    check("abort_count", longint'(sweep_count), 0);

    // ---- loader watchdog ----
    loader_en = 1'b0;
    snap();
    exp_rows.push_back(0);
    push_run(0, 1);
    pulse_run(1);
    k = 0;
    while (!error && k < 100) begin
      @(negedge clk);
      k++;
    end
    lat = (start_cyc.size() > s_start) ? cyc - start_cyc[s_start] : -1;
    check("wd_latency_near_16", longint'(lat >= 15 && lat <= 18), 1);
    wait_done("watchdog", 50);
    repeat (5) @(negedge clk);
    check("wd_cd_pulse", longint'(n_cd - s_cd), 1);
    check("wd_no_update", longint'(n_upd - s_upd), 0);
    check("wd_busy_low", longint'(busy), 0);
    check("wd_error_sticky", longint'(error), 1);
    loader_en = 1'b1;
    snap();
    push_sweep_rows(1);
    push_run(1, 0);
    pulse_run(1);
    check("wd_error_cleared_on_run", longint'(error), 0);
    wait_done("after_wd", 300);

    // ---- reset while in WAIT_LOAD ----
    repeat (2) @(negedge clk);
    snap();
    exp_rows.push_back(0);
    pulse_run(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outputs",
          longint'({start_load, compute_done, upd_start, busy, sweep_done,
                    run_done, error, sweep_count, current_row}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    push_sweep_rows(1);
    push_run(1, 0);
    pulse_run(1);
    check("restart_count_zero", longint'(sweep_count), 0);
    wait_done("restart", 300);

    repeat (4) @(negedge clk);
    check("rows_drained", longint'(exp_rows.size()), 0);
    check("runs_drained", longint'(exp_runs.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
